// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constant helpers for the per-layer stream controllers.
package cnn_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StDone
   } state_t;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned out_dim(input int unsigned img, input int unsigned kernel);
      return img - kernel + 1;
   endfunction

endpackage

// File: rtl/stream_addr_counter.sv
// Loadable, enable-gated up-counter with a terminal-count flag at TC_VAL.
module stream_addr_counter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned TC_VAL = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == WIDTH'(TC_VAL));

endmodule

// File: rtl/layer_stream_ctrl.sv
// Frame sequencer for one conv layer: clear, stream pixels, number the results.
// Optional drain watchdog enabled by defining LAYER_STREAM_CTRL_TIMEOUT_EN.
module layer_stream_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDHT = 32,
   parameter int unsigned CHANNEL_IN = 16,
   parameter int unsigned IMG_WIDHT  = 44,
   parameter int unsigned IMG_HEIGHT = 44,
   parameter int unsigned KERNEL     = 3,
`ifdef LAYER_STREAM_CTRL_TIMEOUT_EN
   parameter int unsigned TIMEOUT    = 4096,
`endif
   localparam int unsigned AW = addr_width(IMG_WIDHT * IMG_HEIGHT),
   localparam int unsigned DW = DATA_WIDHT * CHANNEL_IN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          layer_rst,
   output logic [DW-1:0] layer_data_in,
   output logic          layer_valid_in,
   input  logic          layer_valid_out,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          err
);

   localparam int unsigned NPIX = IMG_WIDHT * IMG_HEIGHT;
   localparam int unsigned NOUT = out_dim(IMG_WIDHT, KERNEL) * out_dim(IMG_HEIGHT, KERNEL);

   state_t        state;
   logic [AW-1:0] in_cnt, out_cnt;
   logic          in_last, out_full, active, last_result, rd_pipe;

`ifdef LAYER_STREAM_CTRL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wd;
`endif

   stream_addr_counter #(.WIDTH(AW), .TC_VAL(NPIX - 1)) u_in_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state == StClear),
      .load_val ('0),
      .en       (state == StFeed),
      .cnt      (in_cnt),
      .tc       (in_last)
   );

   stream_addr_counter #(.WIDTH(AW), .TC_VAL(NOUT)) u_out_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state == StClear),
      .load_val ('0),
      .en       (wr_en),
      .cnt      (out_cnt),
      .tc       (out_full)
   );

   assign active      = (state == StFeed) || (state == StDrain);
   assign wr_en       = layer_valid_out && active && !out_full;
   assign last_result = wr_en && (out_cnt == AW'(NOUT - 1));
   assign rd_addr     = in_cnt;
   assign wr_addr     = out_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= StIdle;
         busy           <= 1'b0;
         done           <= 1'b0;
         rd_en          <= 1'b0;
         rd_pipe        <= 1'b0;
         layer_rst      <= 1'b1;
         layer_valid_in <= 1'b0;
         layer_data_in  <= '0;
         err            <= 1'b0;
`ifdef LAYER_STREAM_CTRL_TIMEOUT_EN
         wd             <= '0;
`endif
      end else begin
         done      <= 1'b0;
         layer_rst <= 1'b1;
         // Buffer returns data one cycle after rd_en; register it for the layer.
         rd_pipe        <= rd_en;
         layer_valid_in <= rd_pipe;
         if (rd_pipe) layer_data_in <= rd_data;
         if (layer_valid_out && (!active || out_full)) err <= 1'b1;
`ifdef LAYER_STREAM_CTRL_TIMEOUT_EN
         if (state != StDrain || layer_valid_out) wd <= '0;
         else wd <= wd + 1'b1;
`endif
         unique case (state)
            StIdle: begin
               if (start) begin
                  state     <= StClear;
                  busy      <= 1'b1;
                  layer_rst <= 1'b0;
                  err       <= 1'b0;
               end
            end
            StClear: begin
               state <= StFeed;
               rd_en <= 1'b1;
            end
            StFeed: begin
               if (in_last) begin
                  state <= StDrain;
                  rd_en <= 1'b0;
               end
            end
            StDrain: begin
               if (out_full || last_result) begin
                  state <= StDone;
                  done  <= 1'b1;
               end
`ifdef LAYER_STREAM_CTRL_TIMEOUT_EN
               else if (!layer_valid_out && wd == TW'(TIMEOUT - 1)) begin
                  state <= StDone;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
`endif
            end
            StDone: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Directed bench for layer_stream_ctrl on a 6x6 frame with a 3x3 kernel.
module tb_layer_stream_ctrl;

   localparam int DW = 512;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst, start, busy, done, rd_en, layer_rst, layer_valid_in;
   logic          layer_valid_out, wr_en, err;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] rd_data, layer_data_in;

   int n_cmp = 0;
   int n_bad = 0;

   // per-frame statistics
   int reads, first_rd, last_rd, vin, first_vin, last_vin, writes, rejected;
   int done_cnt, done_rel, lrst_cnt, lrst_rel, err_at1, busy_after, err_end, busy_end;
   int post_busy, post_rd_en, post_vin;

   always #5 clk = ~clk;

   layer_stream_ctrl #(
      .DATA_WIDHT (32),
      .CHANNEL_IN (16),
      .IMG_WIDHT  (6),
      .IMG_HEIGHT (6),
      .KERNEL     (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .layer_rst       (layer_rst),
      .layer_data_in   (layer_data_in),
      .layer_valid_in  (layer_valid_in),
      .layer_valid_out (layer_valid_out),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .err             (err)
   );

   function automatic logic [DW-1:0] pat(input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(k);
      return {16{w}};
   endfunction

   // Read-only buffer: data valid one cycle after rd_en.
   always @(posedge clk) rd_data <= rd_en ? pat(int'(rd_addr)) : '0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      layer_valid_out = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Cycle 0 is the start cycle; results arrive at res_base + res_step*i, plus extra_res.
   task automatic run_frame(input int len, input int res_base, input int res_step,
                            input int n_res, input int extra_res, input int start2,
                            input int rst_cyc);
      reads = 0; first_rd = -1; last_rd = -1; vin = 0; first_vin = -1; last_vin = -1;
      writes = 0; rejected = 0; done_cnt = 0; done_rel = -1; lrst_cnt = 0; lrst_rel = -1;
      err_at1 = -1; busy_after = -1; post_busy = -1; post_rd_en = -1; post_vin = -1;
      for (int rel = 0; rel < len; rel++) begin
         @(posedge clk);
         #1;
         start = (rel == 0) || (rel == start2);
         rst = (rel == rst_cyc) ? 1'b0 : 1'b1;
         layer_valid_out = (rel == extra_res) ||
                           (n_res > 0 && rel >= res_base && ((rel - res_base) % res_step) == 0
                            && ((rel - res_base) / res_step) < n_res);
         @(negedge clk);
         if (rd_en) begin
            check("rd_addr", DW'(rd_addr), DW'(reads));
            if (first_rd < 0) first_rd = rel;
            last_rd = rel;
            reads++;
         end
         if (layer_valid_in) begin
            check("pix_data", layer_data_in, pat(vin));
            if (first_vin < 0) first_vin = rel;
            last_vin = rel;
            vin++;
         end
         if (wr_en) begin
            check("wr_addr", DW'(wr_addr), DW'(writes));
            writes++;
         end
         if (layer_valid_out && !wr_en) rejected++;
         if (done_cnt > 0 && rel == done_rel + 1) busy_after = int'(busy);
         if (done) begin
            done_cnt++;
            done_rel = rel;
         end
         if (!layer_rst) begin
            lrst_cnt++;
            lrst_rel = rel;
         end
         if (rel == 1) err_at1 = int'(err);
         if (rel == rst_cyc + 1) begin
            post_busy = int'(busy);
            post_rd_en = int'(rd_en);
            post_vin = int'(layer_valid_in);
         end
         busy_end = int'(busy);
         err_end = int'(err);
      end
      start = 1'b0;
      layer_valid_out = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // reset state
      @(negedge clk);
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_rd_en", DW'(rd_en), DW'(0));
      check("rst_rd_addr", DW'(rd_addr), DW'(0));
      check("rst_vin", DW'(layer_valid_in), DW'(0));
      check("rst_data", layer_data_in, '0);
      check("rst_wr_addr", DW'(wr_addr), DW'(0));
      check("rst_wr_en", DW'(wr_en), DW'(0));
      check("rst_err", DW'(err), DW'(0));
      check("rst_layer_rst", DW'(layer_rst), DW'(1));

      // nominal frame, then the same with a stray start at cycle 10
      for (int pass = 0; pass < 2; pass++) begin
         run_frame(56, 20, 2, 16, -1, (pass == 0) ? -1 : 10, -1);
         check("nom_reads", DW'(reads), DW'(36));
         check("nom_first_rd", DW'(first_rd), DW'(2));
         check("nom_last_rd", DW'(last_rd), DW'(37));
         check("nom_vin", DW'(vin), DW'(36));
         check("nom_first_vin", DW'(first_vin), DW'(4));
         check("nom_last_vin", DW'(last_vin), DW'(39));
         check("nom_lrst_cnt", DW'(lrst_cnt), DW'(1));
         check("nom_lrst_rel", DW'(lrst_rel), DW'(1));
         check("nom_writes", DW'(writes), DW'(16));
         check("nom_done_cnt", DW'(done_cnt), DW'(1));
         check("nom_done_rel", DW'(done_rel), DW'(51));
         check("nom_busy_after", DW'(busy_after), DW'(0));
         check("nom_err", DW'(err_end), DW'(0));
      end

      // reset at cycle 20 aborts the frame
      run_frame(30, 20, 2, 0, -1, -1, 20);
      check("abort_reads", DW'(reads), DW'(19));
      check("abort_done", DW'(done_cnt), DW'(0));
      check("abort_busy", DW'(post_busy), DW'(0));
      check("abort_rd_en", DW'(post_rd_en), DW'(0));
      check("abort_vin", DW'(post_vin), DW'(0));
      check("abort_busy_end", DW'(busy_end), DW'(0));
      run_frame(56, 20, 2, 16, -1, -1, -1);
      check("rerun_reads", DW'(reads), DW'(36));
      check("rerun_done", DW'(done_cnt), DW'(1));

      // spurious result while idle
      @(posedge clk);
      #1 layer_valid_out = 1'b1;
      @(negedge clk);
      check("idle_wr_en", DW'(wr_en), DW'(0));
      @(posedge clk);
      #1 layer_valid_out = 1'b0;
      @(negedge clk);
      check("idle_err", DW'(err), DW'(1));

      // all 16 results during FEED, a 17th at the first DRAIN cycle
      run_frame(44, 4, 1, 16, 38, -1, -1);
      check("spur_err_cleared", DW'(err_at1), DW'(0));
      check("spur_writes", DW'(writes), DW'(16));
      check("spur_rejected", DW'(rejected), DW'(1));
      check("spur_done_cnt", DW'(done_cnt), DW'(1));
      check("spur_done_rel", DW'(done_rel), DW'(39));
      check("spur_err", DW'(err_end), DW'(1));

      // only 10 results: without the watchdog the controller waits in DRAIN
      run_frame(120, 20, 2, 10, -1, -1, -1);
      check("short_writes", DW'(writes), DW'(10));
      check("short_done", DW'(done_cnt), DW'(0));
      check("short_busy", DW'(busy_end), DW'(1));
      do_reset();
      @(negedge clk);
      check("short_rst_busy", DW'(busy), DW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
